// File: rtl/alu_issue_pkg.sv
// Opcode/funct7 constants, the issue packet layout and slot occupancy states.
`include "defines_header.svh"

package alu_issue_pkg;

   localparam int unsigned ALU_CTRL_W = `ALU_CONTROL_SIZE;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [ALU_CTRL_W-1:0] alu_control;
      logic [31:0]           src_a;
      logic [31:0]           src_b;
      logic [4:0]            rd;
      logic                  reg_write;
      logic                  illegal;
   } issue_pkt_t;

   typedef enum logic [1:0] {
      SLOT_EMPTY,
      SLOT_MAIN,
      SLOT_BOTH
   } slot_state_t;

   // funct3 -> operation for the funct7=0000000 / OP-IMM row of the map
   function automatic logic [ALU_CTRL_W-1:0] base_alu_op(input logic [2:0] funct3);
      case (funct3)
         3'b000:  return `ALU_ADD;
         3'b001:  return `ALU_SLL;
         3'b010:  return `ALU_SLT;
         3'b011:  return `ALU_SLTU;
         3'b100:  return `ALU_XOR;
         3'b101:  return `ALU_SRL;
         3'b110:  return `ALU_OR;
         default: return `ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I ALU-instruction decode and operand selection.
module alu_issue_decode
   import alu_issue_pkg::*;
(
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   output issue_pkt_t  pkt_o
);

   logic [6:0]            opcode;
   logic [6:0]            funct7;
   logic [2:0]            funct3;
   logic [4:0]            rd;
   logic [31:0]           imm_i;
   logic [31:0]           imm_u;
   logic [ALU_CTRL_W-1:0] op;
   logic [31:0]           opnd_a;
   logic [31:0]           opnd_b;
   logic                  legal;
   logic                  unused_rs1_idx;

   assign opcode         = instr_i[6:0];
   assign rd             = instr_i[11:7];
   assign funct3         = instr_i[14:12];
   assign funct7         = instr_i[31:25];
   assign imm_i          = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_u          = {instr_i[31:12], 12'b0};
   assign unused_rs1_idx = ^instr_i[19:15];

   always_comb begin
      op     = base_alu_op(funct3);
      opnd_a = '0;
      opnd_b = '0;
      legal  = 1'b0;
      case (opcode)
         OPC_OP: begin
            opnd_a = rs1_data_i;
            opnd_b = rs2_data_i;
            if (funct7 == F7_BASE) begin
               legal = 1'b1;
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               legal = 1'b1;
               op    = `ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               legal = 1'b1;
               op    = `ALU_SRA;
            end
         end
         OPC_OP_IMM: begin
            opnd_a = rs1_data_i;
            opnd_b = imm_i;
            case (funct3)
               3'b001:  legal = (funct7 == F7_BASE);
               3'b101: begin
                  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                  if (funct7 == F7_ALT) op = `ALU_SRA;
               end
               default: legal = 1'b1;
            endcase
         end
         OPC_LUI: begin
            legal  = 1'b1;
            op     = `ALU_LUI;
            opnd_b = imm_u;
         end
         OPC_AUIPC: begin
            legal  = 1'b1;
            op     = `ALU_AUIPC;
            opnd_a = pc_i;
            opnd_b = imm_u;
         end
         default: ;
      endcase

      // The ALU shifts by the whole operand, so the shift amount is trimmed here
      if (op == `ALU_SLL || op == `ALU_SRL || op == `ALU_SRA)
         opnd_b = {27'b0, opnd_b[4:0]};

      if (!legal) begin
         op     = `ALU_ADD;
         opnd_a = '0;
         opnd_b = '0;
      end

      pkt_o.alu_control = op;
      pkt_o.src_a       = opnd_a;
      pkt_o.src_b       = opnd_b;
      pkt_o.rd          = rd;
      pkt_o.reg_write   = legal && (rd != 5'd0);
      pkt_o.illegal     = !legal;
   end

endmodule

// File: rtl/defines_header.svh
// Shared ALU control encodings used by the issue stage and the ALU.
`ifndef DEFINES_HEADER_SVH
`define DEFINES_HEADER_SVH
`define ALU_CONTROL_SIZE 4
`define ALU_ADD   4'd0
`define ALU_SUB   4'd1
`define ALU_SLL   4'd2
`define ALU_SLT   4'd3
`define ALU_SLTU  4'd4
`define ALU_XOR   4'd5
`define ALU_SRL   4'd6
`define ALU_SRA   4'd7
`define ALU_OR    4'd8
`define ALU_AND   4'd9
`define ALU_LUI   4'd10
`define ALU_AUIPC 4'd11
`endif

// File: rtl/alu_issue_stage.sv
// ID/EX issue slot: decode plus a 2-entry skid buffer with valid/ready and flush.
module alu_issue_stage
   import alu_issue_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter bit          SKID_EN = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [31:0]           instr_i,
   input  logic [31:0]           pc_i,
   input  logic [XLEN-1:0]       rs1_data_i,
   input  logic [XLEN-1:0]       rs2_data_i,
   input  logic                  flush_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [ALU_CTRL_W-1:0] alu_control_o,
   output logic [XLEN-1:0]       src_a_o,
   output logic [XLEN-1:0]       src_b_o,
   output logic [4:0]            rd_o,
   output logic                  reg_write_o,
   output logic                  illegal_o
);

   slot_state_t state_q, state_d;
   issue_pkt_t  dec_pkt, main_q, skid_q;
   logic        accept, fire;

   alu_issue_decode u_decode (
      .instr_i   (instr_i),
      .pc_i      (pc_i),
      .rs1_data_i(rs1_data_i),
      .rs2_data_i(rs2_data_i),
      .pkt_o     (dec_pkt)
   );

   assign accept = in_valid_i && in_ready_o;
   assign fire   = out_valid_o && out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= SLOT_EMPTY;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = SLOT_EMPTY;
      end else begin
         case (state_q)
            SLOT_EMPTY: if (accept) state_d = SLOT_MAIN;
            SLOT_MAIN: begin
               if (fire && !accept)      state_d = SLOT_EMPTY;
               else if (!fire && accept) state_d = SLOT_BOTH;
            end
            SLOT_BOTH:  if (fire) state_d = SLOT_MAIN;
            default:    state_d = SLOT_EMPTY;
         endcase
      end
   end

   // Without the skid entry, ready must look through to out_ready_i
   always_comb begin
      out_valid_o = (state_q != SLOT_EMPTY);
      if (SKID_EN) in_ready_o = (state_q != SLOT_BOTH);
      else         in_ready_o = (state_q == SLOT_EMPTY) || out_ready_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         main_q <= '0;
         skid_q <= '0;
      end else if (!flush_i) begin
         if (state_q == SLOT_BOTH && fire)
            main_q <= skid_q;
         else if (accept && (state_q == SLOT_EMPTY || fire))
            main_q <= dec_pkt;
         if (SKID_EN && accept && state_q == SLOT_MAIN && !fire)
            skid_q <= dec_pkt;
      end
   end

   assign alu_control_o = main_q.alu_control;
   assign src_a_o       = main_q.src_a;
   assign src_b_o       = main_q.src_b;
   assign rd_o          = main_q.rd;
   assign reg_write_o   = main_q.reg_write;
   assign illegal_o     = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: decode vectors, skid ordering, flush and reset.
`include "defines_header.svh"

module tb_alu_issue_stage;
   import alu_issue_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = '0;
   logic [31:0] pc = '0;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  alu_control;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [4:0]  rd;
   logic        reg_write;
   logic        illegal;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   issue_pkt_t  sb[$];

   always #5 clk = ~clk;

   alu_issue_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .instr_i(instr), .pc_i(pc), .rs1_data_i(rs1), .rs2_data_i(rs2), .flush_i(flush),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .alu_control_o(alu_control),
      .src_a_o(src_a), .src_b_o(src_b), .rd_o(rd), .reg_write_o(reg_write), .illegal_o(illegal)
   );

   function automatic issue_pkt_t model(input logic [31:0] ins, input logic [31:0] pcv,
                                        input logic [31:0] a, input logic [31:0] b);
      logic [3:0]  tbl [8];
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      logic [3:0]  op;
      logic [31:0] sa, sbv;
      logic        ok;
      tbl = '{`ALU_ADD, `ALU_SLL, `ALU_SLT, `ALU_SLTU, `ALU_XOR, `ALU_SRL, `ALU_OR, `ALU_AND};
      opc = ins[6:0];
      f3  = ins[14:12];
      f7  = ins[31:25];
      op  = tbl[f3];
      sa  = a;
      sbv = b;
      ok  = 1'b0;
      if (opc == 7'h33) begin
         ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
         if (f7 == 7'h20) op = (f3 == 3'd0) ? `ALU_SUB : `ALU_SRA;
      end else if (opc == 7'h13) begin
         sbv = {{20{ins[31]}}, ins[31:20]};
         if (f3 == 3'd1)      ok = (f7 == 7'h00);
         else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
         else                 ok = 1'b1;
         if (f3 == 3'd5 && f7 == 7'h20) op = `ALU_SRA;
      end else if (opc == 7'h37) begin
         ok = 1'b1; op = `ALU_LUI; sa = 32'd0; sbv = {ins[31:12], 12'h000};
      end else if (opc == 7'h17) begin
         ok = 1'b1; op = `ALU_AUIPC; sa = pcv; sbv = {ins[31:12], 12'h000};
      end
      if (ok && (opc == 7'h33 || opc == 7'h13) && (f3 == 3'd1 || f3 == 3'd5))
         sbv = sbv & 32'h1f;
      if (!ok) begin
         op = `ALU_ADD; sa = 32'd0; sbv = 32'd0;
      end
      return {op, sa, sbv, ins[11:7], ok && (ins[11:7] != 5'd0), !ok};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0] opc, f7;
      case ($urandom_range(0, 5))
         0, 1:    opc = 7'h33;
         2:       opc = 7'h13;
         3:       opc = 7'h37;
         4:       opc = 7'h17;
         default: opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
         0, 1:    f7 = 7'h00;
         2:       f7 = 7'h20;
         default: f7 = 7'($urandom);
      endcase
      return {f7, 10'($urandom), 3'($urandom), 5'($urandom), opc};
   endfunction

   // One clock: observe handshakes at the negedge, update the scoreboard, return at posedge+1
   task automatic tick(output logic fired, output logic accepted, output issue_pkt_t got,
                       output issue_pkt_t exp, output logic have_exp);
      @(negedge clk);
      fired    = out_valid && out_ready;
      accepted = in_valid && in_ready && !flush;
      got      = {alu_control, src_a, src_b, rd, reg_write, illegal};
      exp      = '0;
      have_exp = 1'b0;
      if (accepted) sb.push_back(model(instr, pc, rs1, rs2));
      if (fired && sb.size() > 0) begin
         exp      = sb.pop_front();
         have_exp = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      n_cmp++;
      if ({alu_control, src_a, src_b, rd, reg_write, illegal} !== 75'd0) begin
         n_bad++;
         $display("FAIL reset_packet: got %h required 0", {alu_control, src_a, src_b, rd, reg_write, illegal});
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pcv;
      logic [31:0] a;
      logic [31:0] b;
      issue_pkt_t  want;
   } dvec_t;

   task automatic test_decode();
      dvec_t      dv [10];
      logic       fired, acc, have;
      issue_pkt_t got, exp;
      dv[0] = '{32'h002081B3, 32'h0, 32'd5, 32'd7, {`ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}};
      dv[1] = '{32'h007312B3, 32'h0, 32'hF0, 32'h23, {`ALU_SLL, 32'hF0, 32'd3, 5'd5, 1'b1, 1'b0}};
      dv[2] = '{32'h40415093, 32'h0, 32'h80000000, 32'h0, {`ALU_SRA, 32'h80000000, 32'd4, 5'd1, 1'b1, 1'b0}};
      dv[3] = '{32'h123450B7, 32'h0, 32'hDEAD, 32'hBEEF, {`ALU_LUI, 32'd0, 32'h12345000, 5'd1, 1'b1, 1'b0}};
      dv[4] = '{32'h00001117, 32'h100, 32'hDEAD, 32'hBEEF, {`ALU_AUIPC, 32'h100, 32'h1000, 5'd2, 1'b1, 1'b0}};
      dv[5] = '{32'h022081B3, 32'h0, 32'd5, 32'd7, {`ALU_ADD, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1}};
      dv[6] = '{32'h00100013, 32'h0, 32'd9, 32'd0, {`ALU_ADD, 32'd9, 32'd1, 5'd0, 1'b0, 1'b0}};
      dv[7] = '{32'h40208233, 32'h0, 32'd5, 32'd7, {`ALU_SUB, 32'd5, 32'd7, 5'd4, 1'b1, 1'b0}};
      dv[8] = '{32'hFFF08313, 32'h0, 32'd20, 32'd0, {`ALU_ADD, 32'd20, 32'hFFFFFFFF, 5'd6, 1'b1, 1'b0}};
      dv[9] = '{32'h40109093, 32'h0, 32'd3, 32'd0, {`ALU_ADD, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1}};
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         instr = dv[i].ins; pc = dv[i].pcv; rs1 = dv[i].a; rs2 = dv[i].b;
         in_valid = 1'b1;
         tick(fired, acc, got, exp, have);
         in_valid = 1'b0;
         n_cmp++;
         if (acc !== 1'b1 || fired !== 1'b0) begin
            n_bad++;
            $display("FAIL decode_accept[%0d]: accepted=%b fired=%b required 1/0", i, acc, fired);
         end
         tick(fired, acc, got, exp, have);
         n_cmp++;
         if (fired !== 1'b1) begin
            n_bad++;
            $display("FAIL decode_latency[%0d]: out_valid=%b one cycle after accept, required 1", i, fired);
         end
         n_cmp++;
         if (got !== dv[i].want) begin
            n_bad++;
            $display("FAIL decode_vector[%0d]: got %h required %h", i, got, dv[i].want);
         end
         n_cmp++;
         if (!have || got !== exp) begin
            n_bad++;
            $display("FAIL decode_scoreboard[%0d]: got %h required %h", i, got, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins [3];
      logic        fired, acc, have;
      issue_pkt_t  got, exp, head;
      int          first_cyc, last_cyc, n_out;
      ins = '{32'h002081B3, 32'h40208233, 32'h0020C3B3};
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         instr = ins[i]; rs1 = 32'd10 + i; rs2 = 32'd3; in_valid = 1'b1;
         tick(fired, acc, got, exp, have);
         n_cmp++;
         if (acc !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_fill[%0d]: accepted=%b required 1", i, acc);
         end
      end
      head = sb[0];
      instr = ins[2]; rs1 = 32'd12; rs2 = 32'd3;
      for (int k = 0; k < 3; k++) begin
         tick(fired, acc, got, exp, have);
         n_cmp++;
         if (in_ready !== 1'b0 || acc !== 1'b0 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_stall_hs[%0d]: in_ready=%b accepted=%b out_valid=%b required 0/0/1", k, in_ready, acc, out_valid);
         end
         n_cmp++;
         if (got !== head) begin
            n_bad++;
            $display("FAIL b2b_stall_hold[%0d]: got %h required %h", k, got, head);
         end
      end
      out_ready = 1'b1;
      n_out = 0; first_cyc = -1; last_cyc = -1;
      for (int c = 0; c < 10; c++) begin
         tick(fired, acc, got, exp, have);
         if (acc) in_valid = 1'b0;
         if (fired) begin
            if (first_cyc < 0) first_cyc = c;
            last_cyc = c;
            n_out++;
            n_cmp++;
            if (!have || got !== exp) begin
               n_bad++;
               $display("FAIL b2b_order[%0d]: got %h required %h", n_out, got, exp);
            end
         end
      end
      n_cmp++;
      if (n_out != 3 || last_cyc - first_cyc != 2 || sb.size() != 0) begin
         n_bad++;
         $display("FAIL b2b_drain: emitted=%0d span=%0d left=%0d required 3/2/0", n_out, last_cyc - first_cyc, sb.size());
      end
      in_valid = 1'b0;
   endtask

   task automatic test_flush();
      logic       fired, acc, have;
      issue_pkt_t got, exp;
      int         n_out;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         instr = 32'h002081B3; rs1 = 32'd40 + i; rs2 = 32'd1; in_valid = 1'b1;
         tick(fired, acc, got, exp, have);
      end
      instr = 32'h0020C3B3; in_valid = 1'b1; flush = 1'b1;
      force_in_ready_check: begin
         n_cmp++;
         if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_full: in_ready=%b with both entries held, required 0", in_ready);
         end
      end
      tick(fired, acc, got, exp, have);
      flush = 1'b0; in_valid = 1'b0;
      sb.delete();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_clear: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      out_ready = 1'b1;
      n_out = 0;
      for (int c = 0; c < 4; c++) begin
         tick(fired, acc, got, exp, have);
         if (fired) n_out++;
      end
      n_cmp++;
      if (n_out != 0) begin
         n_bad++;
         $display("FAIL flush_no_emit: emitted=%0d required 0", n_out);
      end
      instr = 32'h00500093; rs1 = 32'd0; in_valid = 1'b1; out_ready = 1'b0;
      tick(fired, acc, got, exp, have);
      in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
      tick(fired, acc, got, exp, have);
      flush = 1'b0;
      n_cmp++;
      if (!fired || !have || got !== exp) begin
         n_bad++;
         $display("FAIL flush_with_transfer: fired=%b got %h required %h", fired, got, exp);
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_with_transfer_clear: out_valid=%b required 0", out_valid);
      end
      sb.delete();
   endtask

   task automatic test_reset_mid();
      logic       fired, acc, have;
      issue_pkt_t got, exp;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         instr = 32'h007312B3; rs1 = 32'hFF; rs2 = 32'h5; in_valid = (i < 2);
         tick(fired, acc, got, exp, have);
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
          {alu_control, src_a, src_b, rd, reg_write, illegal} !== 75'd0) begin
         n_bad++;
         $display("FAIL reset_mid_stall: out_valid=%b in_ready=%b pkt=%h required 0/1/0", out_valid, in_ready,
                  {alu_control, src_a, src_b, rd, reg_write, illegal});
      end
      sb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic       fired, acc, have;
      issue_pkt_t got, exp;
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         instr = rand_instr(); pc = $urandom; rs1 = $urandom; rs2 = $urandom;
         tick(fired, acc, got, exp, have);
         if (fired) begin
            n_cmp++;
            if (!have || got !== exp) begin
               n_bad++;
               $display("FAIL random_pkt[%0d]: got %h required %h", c, got, exp);
            end
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick(fired, acc, got, exp, have);
         if (fired) begin
            n_cmp++;
            if (!have || got !== exp) begin
               n_bad++;
               $display("FAIL random_drain: got %h required %h", got, exp);
            end
         end
      end
      n_cmp++;
      if (sb.size() != 0 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL random_empty: left=%0d out_valid=%b required 0/0", sb.size(), out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
